program_sequencer: RTL and testbench
====================================

# program_sequencer

Parametrised next-generation MiniRISC program sequencer. It owns the PC, the instruction register and a fetch/decode/execute/interrupt/break state machine. It adds three things the first-generation unit lacks: a configurable PC width, an on-chip return-address stack (RAS) replacing memory-based call/interrupt stacking, and an N-channel prioritised interrupt input. It sits between the program memory and the datapath controller FSM, which reports instruction completion via `exec_done`.

## Interface
- `PC_W`, 8: PC / program address width.
- `IR_W`, 16: instruction width.
- `RAS_DEPTH`, 8: return stack entries; power of 2, at least 2.
- `N_IRQ`, 4: interrupt request channels.
- `RST_VECTOR`, 0: PC value after reset.
- `INT_BASE`, 1: interrupt vector base address.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `prg_mem_addr` out PC_W: equals `pc`.
- `prg_mem_rd` out 1: fetch request.
- `prg_mem_valid` in 1: fetch data valid, allows wait states.
- `prg_mem_din` in IR_W: instruction data.
- `ir` out IR_W: instruction register.
- `decode` out 1: one-cycle pulse while the new `ir` is decoded.
- `exec_done` in 1: pulse from the datapath FSM marking the last execute cycle.
- `ex_jump`, `ex_call`, `ex_ret_sub`, `ex_ret_int` in 1 each: control op, sampled with `exec_done`.
- `jump_addr` in PC_W: jump/call target.
- `ie_set`, `ie_clr` in 1: STI/CLI, sampled with `exec_done`.
- `flags_in` in 4: Z,C,N,V to stack on interrupt entry.
- `flags_out` out 4: restored flags.
- `flags_wr` out 1: pulse, restore flags.
- `irq` in N_IRQ: level-sensitive requests.
- `int_ack` out 1: interrupt entry pulse.
- `int_id` out clog2(N_IRQ): accepted channel, held until next `int_ack`.
- `flag_ie` out 1: interrupt enable.
- `ras_ovf`, `ras_unf` out 1: sticky stack errors.
- `dbg_break`, `dbg_continue`, `dbg_pc_wr` in 1: debug control.
- `dbg_data_in` in PC_W: debug PC value.
- `dbg_is_brk` out 1: break state.

## Operation
- States:
  - FETCH: `prg_mem_rd`=1. Waits for `prg_mem_valid`. On valid: `ir`<=`prg_mem_din`, `pc`<=`pc`+1 mod 2^PC_W, go to DECODE.
  - DECODE: `decode`=1, one cycle, then EXEC.
  - EXEC: waits for `exec_done`.
  - INT: one cycle, then FETCH.
  - BREAK: `dbg_is_brk`=1; `dbg_pc_wr` writes `pc`<=`dbg_data_in`; `dbg_continue` goes to FETCH.
- On `exec_done`, control ops apply with priority jump > call > ret_sub > ret_int; multiple asserted bits are a controller error, and the highest-priority op wins.
  - jump: `pc`<=`jump_addr`.
  - call: push {`pc`, 0, IE}, `pc`<=`jump_addr`.
  - ret_sub: pop; `pc`<=entry PC.
  - ret_int: pop; `pc`<=entry PC, IE<=entry IE, `flags_out`<=entry flags, `flags_wr`=1 for one cycle.
  - IE update priority: `ie_clr` > `ie_set` > ret_int restore.
- EXEC exit, evaluated with `exec_done`: if IE and any `irq` bit is set, go to INT; else if `dbg_break`, go to BREAK; else FETCH. Interrupt beats break.
- INT: lowest-index set `irq` wins; push {`pc`, `flags_in`, IE}; IE<=0; `pc`<=vector; `int_ack`=1; `int_id` updated.
- RAS is circular, width PC_W+5.
  - Push when full: overwrites the oldest entry, count stays at RAS_DEPTH, sets `ras_ovf`.
  - Pop when empty: returns {RST_VECTOR, 0, 0}, count stays 0, sets `ras_unf`.
- Reset (async, any state, mid-fetch included): state FETCH, `pc`=RST_VECTOR, `ir`=0, RAS empty, IE=0, every other output 0. `prg_mem_rd` is 1 immediately after reset because the state is FETCH.

## Timing
- Minimum instruction: 3 cycles (FETCH with immediate valid, DECODE, EXEC with immediate `exec_done`). Each cycle of `prg_mem_valid` low adds one.
- Control-op PC update is visible on the cycle after `exec_done`.
- Interrupt: `irq` seen at `exec_done` -> INT next cycle -> vector fetch the following cycle. IRQ-to-vector-fetch latency after `exec_done` is 2 cycles.
- `flags_wr`, `int_ack` and `decode` are registered single-cycle pulses.
- `dbg_pc_wr` outside BREAK is ignored.

## Configuration
- `PROG_SEQ_VECTORED_INT_EN`:
  - Defined: vector = `INT_BASE` + 2*`int_id`, mod 2^PC_W.
  - Undefined: every channel vectors to `INT_BASE`; software reads `int_id`.

## Test plan
- Reset, then `prg_mem_valid` held 1 and `exec_done` every EXEC: `pc` sequence 0,1,2 with a 3-cycle period; `prg_mem_valid` held low for 2 cycles stretches that fetch to 3 cycles.
- Call at `pc`=0x10 to 0x40, then ret_sub: fetch from 0x40, return fetch at 0x11. A 9th nested call with `RAS_DEPTH`=8 sets `ras_ovf`.
- IE=1, `irq`=4'b1010 at `exec_done`, `pc`=0x21: `int_ack`, `int_id`=1, IE=0, vector 0x03 (macro on) or 0x01 (off). ret_int restores `pc`=0x21, IE=1, and `flags_out`=`flags_in` captured at entry.
- ret_sub on empty RAS: `pc`=RST_VECTOR, `ras_unf`=1 and sticky until reset.
- `dbg_break` together with `irq` and IE=1: INT taken first; break entered after the ISR's first instruction. In BREAK, `dbg_pc_wr` with 0x80, then `dbg_continue`: fetch at 0x80.
- `rst` low asserted while in FETCH waiting on valid: outputs go to reset values immediately; the first fetch after release is from RST_VECTOR.

Source files
------------

// File: rtl/program_sequencer.sv
// MiniRISC program sequencer. It owns the PC and the instruction register, and
// runs the fetch/decode/execute/interrupt/break state machine. It also holds an
// on-chip circular return-address stack and arbitrates N prioritised IRQ lines.
// Build option PROG_SEQ_VECTORED_INT_EN: when defined, channel n enters at
// INT_BASE + 2*n. When undefined, every channel enters at INT_BASE and the ISR
// reads int_id to find the channel.
module program_sequencer #(
    parameter int PC_W       = 8,
    parameter int IR_W       = 16,
    parameter int RAS_DEPTH  = 8,
    parameter int N_IRQ      = 4,
    parameter int RST_VECTOR = 0,
    parameter int INT_BASE   = 1,
    localparam int ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   prg_mem_addr,
    output logic              prg_mem_rd,
    input  logic              prg_mem_valid,
    input  logic [IR_W-1:0]   prg_mem_din,
    output logic [IR_W-1:0]   ir,
    output logic              decode,
    input  logic              exec_done,
    input  logic              ex_jump,
    input  logic              ex_call,
    input  logic              ex_ret_sub,
    input  logic              ex_ret_int,
    input  logic [PC_W-1:0]   jump_addr,
    input  logic              ie_set,
    input  logic              ie_clr,
    input  logic [3:0]        flags_in,
    output logic [3:0]        flags_out,
    output logic              flags_wr,
    input  logic [N_IRQ-1:0]  irq,
    output logic              int_ack,
    output logic [ID_W-1:0]   int_id,
    output logic              flag_ie,
    output logic              ras_ovf,
    output logic              ras_unf,
    input  logic              dbg_break,
    input  logic              dbg_continue,
    input  logic              dbg_pc_wr,
    input  logic [PC_W-1:0]   dbg_data_in,
    output logic              dbg_is_brk
);

    // Stack entry layout: {pc, flags[3:0], ie}
    localparam int E_W   = PC_W + 5;
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PC_W-1:0]  RST_PC   = PC_W'(RST_VECTOR);
    localparam logic [PC_W-1:0]  INT_PC   = PC_W'(INT_BASE);
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_INT,
        S_BREAK
    } state_t;

    state_t state;
    state_t next_state;

    logic [PC_W-1:0]  pc;
    logic [E_W-1:0]   ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W-1:0] ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic [ID_W-1:0]  irq_sel;
    logic [ID_W-1:0]  irq_win;
    logic             irq_any;
    logic             irq_take;
    logic             op_done;
    logic             take_jump;
    logic             take_call;
    logic             take_ret_sub;
    logic             take_ret_int;
    logic             do_push;
    logic             do_pop;
    logic [E_W-1:0]   push_entry;
    logic [E_W-1:0]   pop_entry;
    logic [PC_W-1:0]  int_vector;

    assign prg_mem_addr = pc;

`ifdef PROG_SEQ_VECTORED_INT_EN
    assign int_vector = INT_PC + (PC_W'(irq_sel) << 1);
`else
    assign int_vector = INT_PC;
`endif

    // Pick the lowest-index active request as the interrupt winner
    always_comb begin
        irq_win = '0;
        irq_any = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) begin
                irq_win = ID_W'(i);
                irq_any = 1'b1;
            end
        end
    end

    // Resolve the control op by priority and drive the stack push/pop requests
    always_comb begin
        op_done      = (state == S_EXEC) && exec_done;
        take_jump    = op_done && ex_jump;
        take_call    = op_done && !ex_jump && ex_call;
        take_ret_sub = op_done && !ex_jump && !ex_call && ex_ret_sub;
        take_ret_int = op_done && !ex_jump && !ex_call && !ex_ret_sub && ex_ret_int;
        irq_take     = flag_ie && irq_any;
        do_push      = take_call || (state == S_INT);
        do_pop       = take_ret_sub || take_ret_int;
        push_entry   = (state == S_INT) ? {pc, flags_in, flag_ie} : {pc, 4'b0000, flag_ie};
        ras_top      = ras_ptr - PTR_W'(1);
        pop_entry    = (ras_cnt == '0) ? {RST_PC, 4'b0000, 1'b0} : ras_mem[ras_top];
    end

    // Next-state and state-decoded outputs; an interrupt beats a break request
    always_comb begin
        next_state = state;
        prg_mem_rd = 1'b0;
        dbg_is_brk = 1'b0;
        case (state)
            S_FETCH: begin
                prg_mem_rd = 1'b1;
                if (prg_mem_valid) next_state = S_DECODE;
            end
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (exec_done) begin
                    if (irq_take)       next_state = S_INT;
                    else if (dbg_break) next_state = S_BREAK;
                    else                next_state = S_FETCH;
                end
            end
            S_INT: next_state = S_FETCH;
            S_BREAK: begin
                dbg_is_brk = 1'b1;
                if (dbg_continue) next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= next_state;
    end

    // PC, IR, interrupt-enable and the registered single-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RST_PC;
            ir        <= '0;
            decode    <= 1'b0;
            flags_out <= 4'b0000;
            flags_wr  <= 1'b0;
            int_ack   <= 1'b0;
            int_id    <= '0;
            irq_sel   <= '0;
            flag_ie   <= 1'b0;
        end else begin
            decode   <= 1'b0;
            flags_wr <= 1'b0;
            int_ack  <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (prg_mem_valid) begin
                        ir     <= prg_mem_din;
                        pc     <= pc + PC_W'(1);
                        decode <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        if (take_jump || take_call) pc <= jump_addr;
                        else if (do_pop)            pc <= pop_entry[E_W-1:5];
                        if (take_ret_int) begin
                            flags_out <= pop_entry[4:1];
                            flags_wr  <= 1'b1;
                        end
                        if (ie_clr)            flag_ie <= 1'b0;
                        else if (ie_set)       flag_ie <= 1'b1;
                        else if (take_ret_int) flag_ie <= pop_entry[0];
                        if (irq_take) irq_sel <= irq_win;
                    end
                end
                S_INT: begin
                    pc      <= int_vector;
                    flag_ie <= 1'b0;
                    int_ack <= 1'b1;
                    int_id  <= irq_sel;
                end
                S_BREAK: begin
                    if (dbg_pc_wr) pc <= dbg_data_in;
                end
                default: ;
            endcase
        end
    end

    // Circular return-address stack; overflow drops the oldest entry, underflow
    // hands back the reset vector, and both error flags stay set until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
            ras_ptr <= '0;
            ras_cnt <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else if (do_push) begin
            ras_mem[ras_ptr] <= push_entry;
            ras_ptr          <= ras_ptr + PTR_W'(1);
            if (ras_cnt == RAS_FULL) ras_ovf <= 1'b1;
            else                     ras_cnt <= ras_cnt + CNT_W'(1);
        end else if (do_pop) begin
            if (ras_cnt == '0) begin
                ras_unf <= 1'b1;
            end else begin
                ras_ptr <= ras_top;
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed testbench for program_sequencer with default parameters. Program
// memory returns {8'hA5, address}, so ir reveals which address was fetched.
module tb_program_sequencer;

    localparam logic [5:0] OP_NONE = 6'b000000;
    localparam logic [5:0] OP_JUMP = 6'b100000;
    localparam logic [5:0] OP_CALL = 6'b010000;
    localparam logic [5:0] OP_RS   = 6'b001000;
    localparam logic [5:0] OP_RI   = 6'b000100;
    localparam logic [5:0] OP_IES  = 6'b000010;
    localparam logic [5:0] OP_IEC  = 6'b000001;

`ifdef PROG_SEQ_VECTORED_INT_EN
    localparam logic [7:0] VEC1 = 8'h03;
    localparam logic [7:0] VEC2 = 8'h05;
`else
    localparam logic [7:0] VEC1 = 8'h01;
    localparam logic [7:0] VEC2 = 8'h01;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  prg_mem_addr;
    logic        prg_mem_rd;
    logic        prg_mem_valid = 1'b0;
    logic [15:0] prg_mem_din;
    logic [15:0] ir;
    logic        decode;
    logic        exec_done = 1'b0;
    logic        ex_jump = 1'b0, ex_call = 1'b0, ex_ret_sub = 1'b0, ex_ret_int = 1'b0;
    logic [7:0]  jump_addr = 8'h00;
    logic        ie_set = 1'b0, ie_clr = 1'b0;
    logic [3:0]  flags_in = 4'h0;
    logic [3:0]  flags_out;
    logic        flags_wr;
    logic [3:0]  irq = 4'h0;
    logic        int_ack;
    logic [1:0]  int_id;
    logic        flag_ie;
    logic        ras_ovf, ras_unf;
    logic        dbg_break = 1'b0, dbg_continue = 1'b0, dbg_pc_wr = 1'b0;
    logic [7:0]  dbg_data_in = 8'h00;
    logic        dbg_is_brk;

    int checks = 0;
    int passed = 0;

    assign prg_mem_din = {8'hA5, prg_mem_addr};

    program_sequencer dut (
        .clk(clk), .rst(rst),
        .prg_mem_addr(prg_mem_addr), .prg_mem_rd(prg_mem_rd),
        .prg_mem_valid(prg_mem_valid), .prg_mem_din(prg_mem_din),
        .ir(ir), .decode(decode), .exec_done(exec_done),
        .ex_jump(ex_jump), .ex_call(ex_call), .ex_ret_sub(ex_ret_sub), .ex_ret_int(ex_ret_int),
        .jump_addr(jump_addr), .ie_set(ie_set), .ie_clr(ie_clr),
        .flags_in(flags_in), .flags_out(flags_out), .flags_wr(flags_wr),
        .irq(irq), .int_ack(int_ack), .int_id(int_id), .flag_ie(flag_ie),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf),
        .dbg_break(dbg_break), .dbg_continue(dbg_continue), .dbg_pc_wr(dbg_pc_wr),
        .dbg_data_in(dbg_data_in), .dbg_is_brk(dbg_is_brk)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Run-time guard so a wedged bench always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        prg_mem_valid = 1'b0; exec_done = 1'b0; irq = 4'h0; flags_in = 4'h0;
        {ex_jump, ex_call, ex_ret_sub, ex_ret_int, ie_set, ie_clr} = OP_NONE;
        dbg_break = 1'b0; dbg_continue = 1'b0; dbg_pc_wr = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    // From FETCH: optional wait states, then the valid cycle and DECODE; ends in EXEC
    task automatic fetch_decode(input int waits);
        repeat (waits) step();
        prg_mem_valid = 1'b1;
        step();
        prg_mem_valid = 1'b0;
        step();
    endtask

    // Last EXEC cycle with the given control op
    task automatic exec_op(input logic [5:0] ops, input logic [7:0] target);
        {ex_jump, ex_call, ex_ret_sub, ex_ret_int, ie_set, ie_clr} = ops;
        jump_addr = target;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        {ex_jump, ex_call, ex_ret_sub, ex_ret_int, ie_set, ie_clr} = OP_NONE;
    endtask

    task automatic run_instr(input logic [5:0] ops, input logic [7:0] target);
        fetch_decode(0);
        exec_op(ops, target);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) step();
        checks++; if (prg_mem_addr !== 8'h00) $display("[TB] FAIL rst_addr: got %h expected %h", prg_mem_addr, 8'h00); else passed++;
        checks++;
        if ({prg_mem_rd, decode, int_ack, flags_wr, flag_ie, ras_ovf, ras_unf, dbg_is_brk} !== 8'b1000_0000)
            $display("[TB] FAIL rst_ctrl: got %b expected %b",
                     {prg_mem_rd, decode, int_ack, flags_wr, flag_ie, ras_ovf, ras_unf, dbg_is_brk}, 8'b1000_0000);
        else passed++;
        checks++; if (ir !== 16'h0000) $display("[TB] FAIL rst_ir: got %h expected %h", ir, 16'h0000); else passed++;
        checks++; if ({flags_out, int_id} !== 6'h00) $display("[TB] FAIL rst_flags_id: got %h expected %h", {flags_out, int_id}, 6'h00); else passed++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_sequence();
        checks++; if ({prg_mem_rd, prg_mem_addr} !== 9'h100) $display("[TB] FAIL seq_fetch0: got %h expected %h", {prg_mem_rd, prg_mem_addr}, 9'h100); else passed++;
        prg_mem_valid = 1'b1;
        step();
        prg_mem_valid = 1'b0;
        checks++; if ({decode, prg_mem_rd} !== 2'b10) $display("[TB] FAIL seq_decode: got %b expected %b", {decode, prg_mem_rd}, 2'b10); else passed++;
        checks++; if (ir !== 16'hA500) $display("[TB] FAIL seq_ir0: got %h expected %h", ir, 16'hA500); else passed++;
        checks++; if (prg_mem_addr !== 8'h01) $display("[TB] FAIL seq_pc_inc: got %h expected %h", prg_mem_addr, 8'h01); else passed++;
        step();
        checks++; if ({decode, prg_mem_rd} !== 2'b00) $display("[TB] FAIL seq_exec: got %b expected %b", {decode, prg_mem_rd}, 2'b00); else passed++;
        exec_op(OP_NONE, 8'h00);
        checks++; if ({prg_mem_rd, prg_mem_addr} !== 9'h101) $display("[TB] FAIL seq_fetch1: got %h expected %h", {prg_mem_rd, prg_mem_addr}, 9'h101); else passed++;
        for (int w = 0; w < 2; w++) begin
            step();
            checks++;
            if ({prg_mem_rd, decode, prg_mem_addr} !== 10'h201)
                $display("[TB] FAIL seq_wait%0d: got %h expected %h", w, {prg_mem_rd, decode, prg_mem_addr}, 10'h201);
            else passed++;
        end
        prg_mem_valid = 1'b1;
        step();
        prg_mem_valid = 1'b0;
        checks++; if ({decode, ir} !== {1'b1, 16'hA501}) $display("[TB] FAIL seq_ir1: got %h expected %h", {decode, ir}, {1'b1, 16'hA501}); else passed++;
        step();
        exec_op(OP_NONE, 8'h00);
        checks++; if (prg_mem_addr !== 8'h02) $display("[TB] FAIL seq_fetch2: got %h expected %h", prg_mem_addr, 8'h02); else passed++;
    endtask

    task automatic test_call_ret();
        do_reset();
        run_instr(OP_JUMP, 8'h10);
        checks++; if (prg_mem_addr !== 8'h10) $display("[TB] FAIL jump: got %h expected %h", prg_mem_addr, 8'h10); else passed++;
        run_instr(OP_CALL, 8'h40);
        checks++; if (prg_mem_addr !== 8'h40) $display("[TB] FAIL call_target: got %h expected %h", prg_mem_addr, 8'h40); else passed++;
        run_instr(OP_RS, 8'h00);
        checks++; if (prg_mem_addr !== 8'h11) $display("[TB] FAIL ret_sub: got %h expected %h", prg_mem_addr, 8'h11); else passed++;
        checks++; if (ras_unf !== 1'b0) $display("[TB] FAIL ret_no_unf: got %b expected %b", ras_unf, 1'b0); else passed++;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_instr(OP_CALL, 8'h50 + 8'(i));
            if (i == 7) begin
                checks++; if (ras_ovf !== 1'b0) $display("[TB] FAIL ovf_at_8: got %b expected %b", ras_ovf, 1'b0); else passed++;
            end
        end
        checks++; if (ras_ovf !== 1'b1) $display("[TB] FAIL ovf_at_9: got %b expected %b", ras_ovf, 1'b1); else passed++;
        run_instr(OP_RS, 8'h00);
        checks++; if (prg_mem_addr !== 8'h58) $display("[TB] FAIL ovf_ret: got %h expected %h", prg_mem_addr, 8'h58); else passed++;
    endtask

    task automatic test_priority_unf();
        do_reset();
        run_instr(OP_JUMP | OP_CALL, 8'h30);
        checks++; if (prg_mem_addr !== 8'h30) $display("[TB] FAIL jc_target: got %h expected %h", prg_mem_addr, 8'h30); else passed++;
        run_instr(OP_RS, 8'h00);
        checks++; if ({ras_unf, prg_mem_addr} !== 9'h100) $display("[TB] FAIL unf_ret: got %h expected %h", {ras_unf, prg_mem_addr}, 9'h100); else passed++;
        run_instr(OP_IES, 8'h00);
        checks++; if (flag_ie !== 1'b1) $display("[TB] FAIL ie_set: got %b expected %b", flag_ie, 1'b1); else passed++;
        run_instr(OP_IES | OP_IEC, 8'h00);
        checks++; if (flag_ie !== 1'b0) $display("[TB] FAIL ie_clr_wins: got %b expected %b", flag_ie, 1'b0); else passed++;
        checks++; if (ras_unf !== 1'b1) $display("[TB] FAIL unf_sticky: got %b expected %b", ras_unf, 1'b1); else passed++;
        do_reset();
        checks++; if (ras_unf !== 1'b0) $display("[TB] FAIL unf_reset: got %b expected %b", ras_unf, 1'b0); else passed++;
    endtask

    task automatic test_interrupt();
        do_reset();
        run_instr(OP_JUMP | OP_IES, 8'h20);
        checks++; if ({flag_ie, prg_mem_addr} !== 9'h120) $display("[TB] FAIL int_setup: got %h expected %h", {flag_ie, prg_mem_addr}, 9'h120); else passed++;
        fetch_decode(0);
        flags_in = 4'hB;
        irq = 4'b1010;
        exec_op(OP_NONE, 8'h00);
        checks++; if ({prg_mem_rd, int_ack, prg_mem_addr} !== 10'h021) $display("[TB] FAIL int_state: got %h expected %h", {prg_mem_rd, int_ack, prg_mem_addr}, 10'h021); else passed++;
        irq = 4'h0;
        step();
        flags_in = 4'h0;
        checks++; if ({int_ack, int_id, flag_ie} !== 4'b1010) $display("[TB] FAIL int_ack_id: got %b expected %b", {int_ack, int_id, flag_ie}, 4'b1010); else passed++;
        checks++; if ({prg_mem_rd, prg_mem_addr} !== {1'b1, VEC1}) $display("[TB] FAIL int_vector: got %h expected %h", {prg_mem_rd, prg_mem_addr}, {1'b1, VEC1}); else passed++;
        fetch_decode(0);
        checks++; if (int_ack !== 1'b0) $display("[TB] FAIL int_ack_pulse: got %b expected %b", int_ack, 1'b0); else passed++;
        exec_op(OP_RI, 8'h00);
        checks++; if (prg_mem_addr !== 8'h21) $display("[TB] FAIL reti_pc: got %h expected %h", prg_mem_addr, 8'h21); else passed++;
        checks++; if ({flag_ie, flags_wr, flags_out} !== 6'b11_1011) $display("[TB] FAIL reti_ie_flags: got %b expected %b", {flag_ie, flags_wr, flags_out}, 6'b11_1011); else passed++;
        step();
        checks++; if ({flags_wr, int_id} !== 3'b001) $display("[TB] FAIL flags_wr_pulse: got %b expected %b", {flags_wr, int_id}, 3'b001); else passed++;
    endtask

    task automatic test_break();
        do_reset();
        run_instr(OP_IES, 8'h00);
        dbg_data_in = 8'h99;
        dbg_pc_wr = 1'b1;
        step();
        dbg_pc_wr = 1'b0;
        checks++; if (prg_mem_addr !== 8'h01) $display("[TB] FAIL pcwr_ignored: got %h expected %h", prg_mem_addr, 8'h01); else passed++;
        fetch_decode(0);
        irq = 4'b0100;
        dbg_break = 1'b1;
        exec_op(OP_NONE, 8'h00);
        checks++; if ({dbg_is_brk, prg_mem_rd} !== 2'b00) $display("[TB] FAIL int_before_brk: got %b expected %b", {dbg_is_brk, prg_mem_rd}, 2'b00); else passed++;
        irq = 4'h0;
        step();
        checks++; if ({int_id, prg_mem_addr} !== {2'd2, VEC2}) $display("[TB] FAIL brk_isr_vec: got %h expected %h", {int_id, prg_mem_addr}, {2'd2, VEC2}); else passed++;
        run_instr(OP_NONE, 8'h00);
        checks++; if ({dbg_is_brk, prg_mem_rd} !== 2'b10) $display("[TB] FAIL brk_entry: got %b expected %b", {dbg_is_brk, prg_mem_rd}, 2'b10); else passed++;
        dbg_break = 1'b0;
        dbg_data_in = 8'h80;
        dbg_pc_wr = 1'b1;
        step();
        dbg_pc_wr = 1'b0;
        checks++; if ({dbg_is_brk, prg_mem_addr} !== 9'h180) $display("[TB] FAIL brk_pcwr: got %h expected %h", {dbg_is_brk, prg_mem_addr}, 9'h180); else passed++;
        dbg_continue = 1'b1;
        step();
        dbg_continue = 1'b0;
        checks++; if ({dbg_is_brk, prg_mem_rd, prg_mem_addr} !== 10'h180) $display("[TB] FAIL brk_continue: got %h expected %h", {dbg_is_brk, prg_mem_rd, prg_mem_addr}, 10'h180); else passed++;
        prg_mem_valid = 1'b1;
        step();
        prg_mem_valid = 1'b0;
        checks++; if (ir !== 16'hA580) $display("[TB] FAIL brk_fetch_ir: got %h expected %h", ir, 16'hA580); else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        run_instr(OP_RS, 8'h00);
        run_instr(OP_JUMP | OP_IES, 8'h44);
        step();
        checks++; if ({ras_unf, flag_ie, prg_mem_addr} !== 10'h344) $display("[TB] FAIL pre_reset: got %h expected %h", {ras_unf, flag_ie, prg_mem_addr}, 10'h344); else passed++;
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({prg_mem_rd, prg_mem_addr} !== 9'h100) $display("[TB] FAIL async_rst_addr: got %h expected %h", {prg_mem_rd, prg_mem_addr}, 9'h100); else passed++;
        checks++; if ({ras_unf, flag_ie, ir} !== 18'h0) $display("[TB] FAIL async_rst_regs: got %h expected %h", {ras_unf, flag_ie, ir}, 18'h0); else passed++;
        step();
        rst = 1'b1;
        prg_mem_valid = 1'b1;
        step();
        prg_mem_valid = 1'b0;
        checks++; if ({decode, ir, prg_mem_addr} !== {1'b1, 16'hA500, 8'h01}) $display("[TB] FAIL post_rst_fetch: got %h expected %h", {decode, ir, prg_mem_addr}, {1'b1, 16'hA500, 8'h01}); else passed++;
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] program_sequencer directed test start");
        test_reset();
        test_sequence();
        test_call_ret();
        test_priority_unf();
        test_interrupt();
        test_break();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
